// File: rtl/hub75_scan.sv
// HUB75 LED panel scanner: reads a {half,row,col} frame buffer and drives binary-coded-modulation bit planes.
// Latency: a plane takes 4*COLS+2 shift/tail cycles, 1 blank, 1 latch, then (max(base,1) << plane) lit cycles.
// Backpressure: none; the frame buffer must return data one cycle after each read enable, and en is sampled only at plane end.
// Ports:
//   clk, resetn (sync, active-low), en (scan enable), base_time (plane-0 lit cycles)
//   bram_en/bram_addr/bram_dout : frame-buffer read port, address {half,row,col}, data [23:16]=R [15:8]=G [7:0]=B
//   hub_r1/g1/b1, hub_r2/g2/b2   : upper/lower half colour bits
//   hub_clk, hub_lat, hub_oe_n, hub_row : panel shift clock, latch, output enable (active-low), row select
//   busy (not idle), frame_done (one-cycle pulse after the last plane of the last row)
module hub75_scan #(
  parameter int COL_BITS   = 6,
  parameter int ROW_BITS   = 5,
  parameter int BIT_DEPTH  = 8,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = 1 + ROW_BITS + COL_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [15:0]           base_time,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  hub_r1,
  output logic                  hub_g1,
  output logic                  hub_b1,
  output logic                  hub_r2,
  output logic                  hub_g2,
  output logic                  hub_b2,
  output logic                  hub_clk,
  output logic                  hub_lat,
  output logic                  hub_oe_n,
  output logic [ROW_BITS-1:0]   hub_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_TAIL    = 3'd2;
  localparam logic [2:0] S_BLANK   = 3'd3;
  localparam logic [2:0] S_LATCH   = 3'd4;
  localparam logic [2:0] S_DISPLAY = 3'd5;

  localparam logic [2:0] LAST_PLANE = 3'(BIT_DEPTH - 1);
  // Planes are MSB-aligned inside each 8-bit channel.
  localparam logic [2:0] BIT_OFS    = 3'(8 - BIT_DEPTH);

  logic [2:0]          state;
  logic [2:0]          plane;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [1:0]          kph;       // phase k0..k3 inside a column slot
  logic                tail_cnt;
  logic [15:0]         base;      // base_time frozen for the whole frame
  logic [23:0]         disp_cnt;
  logic [23:0]         upper_q;

  logic [23:0]         disp_len;
  logic [1:0]          nkph;
  logic [COL_BITS-1:0] ncol;
  logic                last_plane;
  logic                last_row;
  logic [2:0]          nplane;
  logic [ROW_BITS-1:0] nrow;

  logic unused_hi;
  assign unused_hi = ^bram_dout[DATA_WIDTH-1:24];

  function automatic logic pick(input logic [7:0] ch, input logic [2:0] p);
    logic [7:0] s;
    s = ch >> (BIT_OFS + p);
    return s[0];
  endfunction

  always_comb begin
    // 16-bit base shifted by at most 7 fits in 24 bits.
    disp_len   = {8'd0, (base == 16'd0) ? 16'd1 : base} << plane;
    nkph       = kph + 2'd1;
    ncol       = (kph == 2'd3) ? col + COL_BITS'(1) : col;
    last_plane = (plane == LAST_PLANE);
    last_row   = (row == '1);
    nplane     = last_plane ? 3'd0 : plane + 3'd1;
    nrow       = last_plane ? row + ROW_BITS'(1) : row;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      plane      <= '0;
      row        <= '0;
      col        <= '0;
      kph        <= '0;
      tail_cnt   <= 1'b0;
      base       <= '0;
      disp_cnt   <= '0;
      upper_q    <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      hub_r1     <= 1'b0;
      hub_g1     <= 1'b0;
      hub_b1     <= 1'b0;
      hub_r2     <= 1'b0;
      hub_g2     <= 1'b0;
      hub_b2     <= 1'b0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_row    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state     <= S_SHIFT;
            row       <= '0;
            plane     <= '0;
            col       <= '0;
            kph       <= '0;
            base      <= base_time;
            busy      <= 1'b1;
            bram_en   <= 1'b1;
            bram_addr <= '0;
          end
        end
        S_SHIFT: begin
          if (kph == 2'd1) upper_q <= bram_dout[23:0];
          // Both halves change together so every panel edge sees a coherent pair.
          if (kph == 2'd2) begin
            hub_r1 <= pick(upper_q[23:16], plane);
            hub_g1 <= pick(upper_q[15:8], plane);
            hub_b1 <= pick(upper_q[7:0], plane);
            hub_r2 <= pick(bram_dout[23:16], plane);
            hub_g2 <= pick(bram_dout[15:8], plane);
            hub_b2 <= pick(bram_dout[7:0], plane);
          end
          if (kph == 2'd3 && col == '1) begin
            state    <= S_TAIL;
            tail_cnt <= 1'b0;
            bram_en  <= 1'b0;
            hub_clk  <= 1'b1;      // clocks in the last column
          end else begin
            kph       <= nkph;
            col       <= ncol;
            bram_en   <= !nkph[1];
            bram_addr <= {nkph[0], row, ncol};
            // The rising edge at slot c shifts in column c-1; slot 0 has none.
            hub_clk   <= !nkph[1] && (ncol != '0);
          end
        end
        S_TAIL: begin
          if (tail_cnt) begin
            state   <= S_BLANK;
            hub_clk <= 1'b0;
          end else begin
            tail_cnt <= 1'b1;
          end
        end
        S_BLANK: begin
          hub_row <= row;
          hub_lat <= 1'b1;
          state   <= S_LATCH;
        end
        S_LATCH: begin
          hub_lat  <= 1'b0;
          hub_oe_n <= 1'b0;
          disp_cnt <= disp_len - 24'd1;
          state    <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (disp_cnt != '0) begin
            disp_cnt <= disp_cnt - 24'd1;
          end else begin
            hub_oe_n <= 1'b1;
            if (last_plane && last_row) begin
              frame_done <= 1'b1;
              base       <= base_time;
            end
            if (en) begin
              state     <= S_SHIFT;
              row       <= nrow;
              plane     <= nplane;
              col       <= '0;
              kph       <= '0;
              bram_en   <= 1'b1;
              bram_addr <= {1'b0, nrow, {COL_BITS{1'b0}}};
            end else begin
              state <= S_IDLE;
              row   <= '0;
              plane <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan.sv
// Self-checking bench for hub75_scan with a 4x2 panel, 2 bit planes and a 1-cycle frame buffer.
// Expected panel traffic is derived from the frame-buffer contents and the scan rules.
// Stimulus is a directed sequence with randomized frame contents and base times.
module tb_hub75_scan;
  localparam int CB = 2;
  localparam int RB = 1;
  localparam int BD = 2;
  localparam int DW = 32;
  localparam int AW = 1 + RB + CB;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   base_time = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic          hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic          hub_clk, hub_lat, hub_oe_n;
  logic [RB-1:0] hub_row;
  logic          busy, frame_done;

  hub75_scan #(.COL_BITS(CB), .ROW_BITS(RB), .BIT_DEPTH(BD), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .en(en), .base_time(base_time),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_row(hub_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [5:0] edge_q [$];
  int oe_run_q [$];
  int lat_row_q [$];
  int lat_cyc_q [$];
  int oe_len = 0;
  int fd_cnt = 0;
  int fd_viol = 0;
  int setup_viol = 0;
  int hold_viol = 0;
  int since_edge = 1000;
  logic prev_clk = 1'b0;
  logic prev_oe_n = 1'b1;
  logic prev_fd = 1'b0;
  logic [5:0] prev_col = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and log panel events.
  task automatic tick();
    logic [5:0] colours;
    @(posedge clk);
    #1;
    cyc++;
    colours = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};
    if (hub_clk === 1'b1 && prev_clk !== 1'b1) begin
      edge_q.push_back(colours);
      if (colours !== prev_col) setup_viol++;
      since_edge = 0;
    end else begin
      if (since_edge < 1000) since_edge++;
      if (colours !== prev_col && since_edge < 2) hold_viol++;
    end
    if (hub_oe_n === 1'b0) oe_len++;
    else if (oe_len > 0) begin
      oe_run_q.push_back(oe_len);
      oe_len = 0;
    end
    if (hub_lat === 1'b1) begin
      lat_row_q.push_back(int'(hub_row));
      lat_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (prev_oe_n !== 1'b0 || prev_fd === 1'b1) fd_viol++;
    end
    prev_clk  = hub_clk;
    prev_col  = colours;
    prev_oe_n = hub_oe_n;
    prev_fd   = frame_done;
  endtask

  task automatic clear_obs();
    edge_q.delete();
    oe_run_q.delete();
    lat_row_q.delete();
    lat_cyc_q.delete();
    oe_len = 0;
  endtask

  // Panel bits {r1,g1,b1,r2,g2,b2} expected at the edge for column c of row r, plane p.
  function automatic logic [5:0] exp_edge(input int r, input int p, input int c);
    logic [31:0] su, sl;
    su = mem[r * 4 + c] >> (8 - BD + p);
    sl = mem[8 + r * 4 + c] >> (8 - BD + p);
    return {su[16], su[8], su[0], sl[16], sl[8], sl[0]};
  endfunction

  task automatic check_frame(input int base);
    int b;
    int exp_oe [4];
    b = (base == 0) ? 1 : base;
    for (int k = 0; k < 4; k++) exp_oe[k] = b << (k % 2);
    chk("frame_edge_count", edge_q.size(), 16);
    chk("frame_latch_count", lat_row_q.size(), 4);
    chk("frame_oe_runs", oe_run_q.size(), 4);
    for (int i = 0; i < 16 && i < edge_q.size(); i++)
      chk($sformatf("edge_data[%0d]", i), edge_q[i], exp_edge(i / 8, (i / 4) % 2, i % 4));
    for (int k = 0; k < 4 && k < oe_run_q.size(); k++)
      chk($sformatf("oe_low_len[%0d]", k), oe_run_q[k], exp_oe[k]);
    for (int k = 0; k < 4 && k < lat_row_q.size(); k++)
      chk($sformatf("latch_row[%0d]", k), lat_row_q[k], k / 2);
    for (int k = 1; k < 4 && k < lat_cyc_q.size(); k++)
      chk($sformatf("latch_gap[%0d]", k), lat_cyc_q[k] - lat_cyc_q[k-1], exp_oe[k-1] + 20);
    chk("setup_violations", setup_viol, 0);
    chk("hold_violations", hold_viol, 0);
    chk("frame_done_shape", fd_viol, 0);
  endtask

  initial begin
    int c0, start, cur_base, next_base, fb;
    logic [5:0] want [8];

    resetn = 1'b0;
    en = 1'b1;
    base_time = 16'd3;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h800000; mem[1] = 32'h008000; mem[2] = 32'h000080; mem[3] = 32'hC0C0C0;
    for (int i = 8; i < 12; i++) mem[i] = 32'h0;

    // Reset held with en already high.
    repeat (3) tick();
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_colours", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, 0);
    chk("rst_hub_clk", hub_clk, 0);
    chk("rst_hub_lat", hub_lat, 0);
    chk("rst_hub_oe_n", hub_oe_n, 1);
    chk("rst_hub_row", hub_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    resetn = 1'b1;
    tick();
    c0 = cyc;
    chk("start_busy", busy, 1);
    chk("start_bram_en", bram_en, 1);
    chk("start_bram_addr", bram_addr, 0);
    base_time = 16'd0;   // frame 1 already holds 3; frame 2 must pick up 0
    cur_base = 3;
    next_base = 0;

    want = '{6'b000000, 6'b000000, 6'b000000, 6'b111000,
             6'b100000, 6'b010000, 6'b001000, 6'b111000};

    for (int f = 1; f <= 5; f++) begin
      start = fd_cnt;
      for (int i = 0; i < 600 && fd_cnt == start; i++) tick();
      chk("frame_done_seen", fd_cnt - start, 1);
      if (f == 1) begin
        chk("first_latch_cycle", (lat_cyc_q.size() > 0) ? lat_cyc_q[0] - c0 : -1, 19);
        for (int i = 0; i < 8 && i < edge_q.size(); i++)
          chk($sformatf("row0_directed_edge[%0d]", i), edge_q[i], want[i]);
      end
      check_frame(cur_base);
      chk("busy_next_frame", busy, 1);
      clear_obs();
      cur_base = next_base;
      next_base = $urandom_range(0, 4);
      base_time = 16'(next_base);
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
    end

    // Drop en while row 0 plane 0 is shifting: that plane still completes.
    start = fd_cnt;
    repeat (3) tick();
    en = 1'b0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
    chk("drop_busy", busy, 0);
    chk("drop_oe_n", hub_oe_n, 1);
    chk("drop_edge_count", edge_q.size(), 4);
    for (int c = 0; c < 4 && c < edge_q.size(); c++)
      chk($sformatf("drop_edge[%0d]", c), edge_q[c], exp_edge(0, 0, c));
    chk("drop_latch_count", lat_row_q.size(), 1);
    chk("drop_oe_len", (oe_run_q.size() > 0) ? oe_run_q[0] : -1, (cur_base == 0) ? 1 : cur_base);
    repeat (10) tick();
    chk("idle_busy", busy, 0);
    chk("idle_bram_en", bram_en, 0);
    chk("idle_hub_clk", hub_clk, 0);
    chk("idle_no_latch", lat_row_q.size(), 1);
    chk("idle_hub_row", hub_row, 0);
    chk("idle_no_frame_done", fd_cnt - start, 0);

    // Re-enable restarts at row 0 plane 0; then reset in the middle of DISPLAY.
    clear_obs();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    base_time = 16'd5;
    en = 1'b1;
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_bram_addr", bram_addr, 0);
    for (int i = 0; i < 100 && hub_oe_n !== 1'b0; i++) tick();
    chk("restart_oe_low", hub_oe_n, 0);
    chk("restart_latch_row", (lat_row_q.size() == 1) ? lat_row_q[0] : -1, 0);
    chk("restart_edge_count", edge_q.size(), 4);
    for (int c = 0; c < 4 && c < edge_q.size(); c++)
      chk($sformatf("restart_edge[%0d]", c), edge_q[c], exp_edge(0, 0, c));
    tick();
    resetn = 1'b0;
    tick();
    chk("midrst_oe_n", hub_oe_n, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_hub_lat", hub_lat, 0);
    chk("midrst_bram_en", bram_en, 0);
    chk("midrst_hub_row", hub_row, 0);
    chk("midrst_colours", {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}, 0);
    resetn = 1'b1;
    en = 1'b0;
    clear_obs();
    repeat (30) tick();
    chk("postrst_no_latch", lat_row_q.size(), 0);
    chk("postrst_no_oe_runs", oe_run_q.size(), 0);
    chk("postrst_oe_len", oe_len, 0);
    chk("postrst_busy", busy, 0);

    // One more full frame from idle with a random base.
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    fb = $urandom_range(0, 4);
    base_time = 16'(fb);
    en = 1'b1;
    start = fd_cnt;
    for (int i = 0; i < 600 && fd_cnt == start; i++) tick();
    chk("final_frame_done_seen", fd_cnt - start, 1);
    check_frame(fb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
HUB75_SCAN -- requirements
Module: hub75_scan

Interface
REQ-001 Parameter COL_BITS, default 6: log2 of panel columns (COLS = 2**COL_BITS).
REQ-002 Parameter ROW_BITS, default 5: log2 of scanned row pairs (ROWS = 2**ROW_BITS).
REQ-003 Parameter BIT_DEPTH, default 8, legal 1..8: bit planes per frame.
REQ-004 Parameter DATA_WIDTH, default 32: pixel word width; [23:16]=R, [15:8]=G, [7:0]=B, upper bits ignored.
REQ-005 Derived ADDR_WIDTH = 1+ROW_BITS+COL_BITS; frame-buffer address = {half, row, col}, half 0 = upper panel half, 1 = lower.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 en  in  1  scan enable.
REQ-009 base_time  in  16  display cycles for plane 0.
REQ-010 bram_en  out  1  frame-buffer read enable.
REQ-011 bram_addr  out  ADDR_WIDTH  frame-buffer read address.
REQ-012 bram_dout  in  DATA_WIDTH  frame-buffer read data, valid one cycle after bram_en/bram_addr.
REQ-013 hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2  out  1 each  upper/lower half colour bits.
REQ-014 hub_clk, hub_lat, hub_oe_n  out  1 each  panel shift clock, latch, output enable (active-low).
REQ-015 hub_row  out  ROW_BITS  panel row select.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frame_done  out  1  one-cycle pulse at end of each frame.

Function
REQ-018 States: IDLE, SHIFT, TAIL, BLANK, LATCH, DISPLAY; all outputs registered.
REQ-019 IDLE: en=1 -> SHIFT with row=0, plane=0, base_time captured; captured value held for whole frame.
REQ-020 SHIFT: COLS slots of 4 cycles (k0..k3) per column c = 0..COLS-1.
REQ-021 k0: bram_en=1, bram_addr={0,row,c}; k1: bram_en=1, bram_addr={1,row,c}; bram_en=0 in k2,k3.
REQ-022 Upper word captured at end of k1, lower word at end of k2; all six colour outputs update together at end of k2.
REQ-023 Colour bit for plane p = channel bit (8-BIT_DEPTH+p), MSB-aligned.
REQ-024 hub_clk=1 during k0,k1 of slot c>0 and during TAIL; 0 otherwise; first slot produces no edge.
REQ-025 TAIL: 2 cycles, hub_clk=1, data held; -> BLANK. Exactly COLS hub_clk rising edges per plane, data stable >=1 cycle before and >=2 cycles after each.
REQ-026 BLANK: 1 cycle, hub_row <= row at its end; -> LATCH.
REQ-027 LATCH: 1 cycle, hub_lat=1; -> DISPLAY.
REQ-028 DISPLAY: hub_oe_n=0 for exactly max(base,1) << plane cycles (base 0 treated as 1), computed in 24 bits, no overflow; hub_oe_n=1 in all other states.
REQ-029 End of DISPLAY: plane++; plane wrap BIT_DEPTH-1 -> 0 increments row; row wrap ROWS-1 -> 0 pulses frame_done in the following cycle and recaptures base_time.
REQ-030 en sampled only at end of DISPLAY: en=0 -> IDLE, row/plane cleared; en=1 -> SHIFT. en drop mid-plane completes that plane including DISPLAY.
REQ-031 IDLE outputs: bram_en=0, hub_clk=0, hub_lat=0, hub_oe_n=1, busy=0; hub_row and colour outputs hold.

Reset
REQ-032 resetn=0 at a clk edge: state IDLE, row=0, plane=0, bram_en=0, bram_addr=0, colour outputs 0, hub_clk=0, hub_lat=0, hub_oe_n=1, hub_row=0, busy=0, frame_done=0.
REQ-033 Reset mid-operation takes effect the next edge regardless of state; no partial latch or OE pulse afterwards.

Verification (COL_BITS=2, ROW_BITS=1, BIT_DEPTH=2, 1-cycle BRAM model)
REQ-034 Reset held 3 cycles, en=1 -> all outputs at REQ-032 values, hub_oe_n=1.
REQ-035 Upper row0 words 0x800000,0x008000,0x000080,0xC0C0C0, lower 0 -> plane 1 edges sample r1g1b1 = 100,010,001,111; plane 0 (bit 6) samples 000,000,000,111; 4 edges per plane, SHIFT+TAIL = 18 cycles.
REQ-036 base_time=3 -> oe_n low 3 cycles plane 0, 6 cycles plane 1; BLANK, LATCH each 1 cycle, oe_n high between.
REQ-037 base_time=0 -> oe_n low 1 then 2 cycles; frame_done single pulse after row 1 plane 1, hub_row returns 0, next frame starts.
REQ-038 en dropped during SHIFT of row 0 plane 0 -> DISPLAY completes, then IDLE, busy=0, oe_n=1; re-enable restarts at row 0 plane 0.
REQ-039 resetn low during DISPLAY -> next cycle oe_n=1, busy=0; no hub_lat pulse until a new SHIFT.
